// File: rtl/opsum_arb_pkg.sv
// rtl/opsum_arb_pkg.sv - shared defaults and GLB write record for the opsum write arbiter
package opsum_arb_pkg;

  localparam int OPSUM_NUM_CH = 8;
  localparam int OPSUM_DATA_W = 32;
  localparam int OPSUM_ADDR_W = 32;
  localparam int OPSUM_WEB_W  = OPSUM_DATA_W / 8;

  // One GLB write as held by the output stage and seen by the GLB-side consumer
  typedef struct packed {
    logic [OPSUM_ADDR_W-1:0] addr;
    logic [OPSUM_WEB_W-1:0]  web;
    logic [OPSUM_DATA_W-1:0] data;
  } glb_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Scan ptr, ptr+1, ... modulo N and take the first requester found
  always_comb begin
    int c;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    c         = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (en && !gnt_valid && req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(c);
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/opsum_glb_write_arbiter.sv
// rtl/opsum_glb_write_arbiter.sv - round-robin merge of opsum FIFO writes onto the GLB write port
module opsum_glb_write_arbiter
  import opsum_arb_pkg::*;
#(
  parameter int NUM_CH = OPSUM_NUM_CH,
  parameter int DATA_W = OPSUM_DATA_W,
  parameter int ADDR_W = OPSUM_ADDR_W,
  parameter int WEB_W  = OPSUM_WEB_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*WEB_W-1:0]  web_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic [NUM_CH-1:0]        permit_pop_o,
  output logic                     glb_valid_o,
  output logic [ADDR_W-1:0]        glb_addr_o,
  output logic [WEB_W-1:0]         glb_web_o,
  output logic [DATA_W-1:0]        glb_wdata_o,
  input  logic                     glb_ready_i,
  input  logic                     cnt_clr_i,
  output logic [CNT_W-1:0]         wr_cnt_o,
  output logic                     busy_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             slot_free;
  logic             handshake;
  logic             valid_q;
  glb_wr_t          stage_q;
  logic [CNT_W-1:0] cnt_q;

  // The slot can take a new write when empty or when it drains this same cycle
  assign slot_free = !valid_q || glb_ready_i;
  assign handshake = valid_q && glb_ready_i;

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_i),
    .ptr       (rr_ptr),
    .en        (slot_free && !rst),
    .gnt       (permit_pop_o),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Round-robin pointer moves just past the winner; idle cycles leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      rr_ptr <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // Single-entry output stage: reload on grant, empty on drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else if (gnt_valid) begin
      valid_q      <= 1'b1;
      stage_q.addr <= addr_i[gnt_idx*ADDR_W +: ADDR_W];
      stage_q.web  <= web_i[gnt_idx*WEB_W +: WEB_W];
      stage_q.data <= data_i[gnt_idx*DATA_W +: DATA_W];
    end else if (handshake) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating handshake counter; a clear still counts the write completing with it
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= handshake ? CNT_W'(1) : '0;
    end else if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign glb_valid_o = valid_q;
  assign glb_addr_o  = stage_q.addr;
  assign glb_web_o   = stage_q.web;
  assign glb_wdata_o = stage_q.data;
  assign wr_cnt_o    = cnt_q;
  assign busy_o      = valid_q || (|req_i);

endmodule

// File: tb/tb_opsum_glb_write_arbiter.sv
// tb/tb_opsum_glb_write_arbiter.sv - directed self-checking bench for opsum_glb_write_arbiter
module tb_opsum_glb_write_arbiter;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_i;
  logic [N*AW-1:0] addr_i;
  logic [N*WW-1:0] web_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]  permit_pop_o;
  logic          glb_valid_o;
  logic [AW-1:0] glb_addr_o;
  logic [WW-1:0] glb_web_o;
  logic [DW-1:0] glb_wdata_o;
  logic          glb_ready_i;
  logic          cnt_clr_i;
  logic [15:0]   wr_cnt_o;
  logic          busy_o;

  logic [N-1:0]  s_permit;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [WW-1:0] s_web;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_cnt;
  logic          s_busy;

  logic [AW-1:0] ch_addr [N];
  logic [DW-1:0] ch_data [N];
  logic [WW-1:0] ch_web  [N];

  int checks = 0;
  int errors = 0;

  opsum_glb_write_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .web_i(web_i), .data_i(data_i),
    .permit_pop_o(permit_pop_o), .glb_valid_o(glb_valid_o), .glb_addr_o(glb_addr_o),
    .glb_web_o(glb_web_o), .glb_wdata_o(glb_wdata_o), .glb_ready_i(glb_ready_i),
    .cnt_clr_i(cnt_clr_i), .wr_cnt_o(wr_cnt_o), .busy_o(busy_o)
  );

  // Narrow-counter copy sharing all stimulus, used to reach saturation quickly
  opsum_glb_write_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .web_i(web_i), .data_i(data_i),
    .permit_pop_o(s_permit), .glb_valid_o(s_valid), .glb_addr_o(s_addr),
    .glb_web_o(s_web), .glb_wdata_o(s_wdata), .glb_ready_i(glb_ready_i),
    .cnt_clr_i(cnt_clr_i), .wr_cnt_o(s_cnt), .busy_o(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    addr_i = '0;
    web_i  = '0;
    data_i = '0;
    for (int k = 0; k < N; k++) begin
      addr_i[k*AW +: AW] = ch_addr[k];
      web_i[k*WW +: WW]  = ch_web[k];
      data_i[k*DW +: DW] = ch_data[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      ch_addr[k] = 32'h1000 + 32'(k) * 32'h10;
      ch_data[k] = 32'hC0DE_0000 + 32'(k);
      ch_web[k]  = 4'(k + 1);
    end
    rst = 1'b1; req_i = '0; glb_ready_i = 1'b0; cnt_clr_i = 1'b0;
    @(negedge clk);
    tick();

    // reset state
    check("rst_valid", 64'(glb_valid_o), 64'd0);
    check("rst_addr",  64'(glb_addr_o), 64'd0);
    check("rst_wdata", 64'(glb_wdata_o), 64'd0);
    check("rst_web",   64'(glb_web_o), 64'd0);
    check("rst_cnt",   64'(wr_cnt_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    req_i = 8'hFF; #1;
    check("rst_permit_forced", 64'(permit_pop_o), 64'd0);
    req_i = '0;
    @(negedge clk);
    rst = 1'b0;

    // single requester on channel 2
    ch_addr[2] = 32'h100; ch_data[2] = 32'hDEAD_BEEF; ch_web[2] = 4'hF;
    req_i = 8'b0000_0100; glb_ready_i = 1'b1; #1;
    check("single_permit", 64'(permit_pop_o), 64'h04);
    check("single_busy", 64'(busy_o), 64'd1);
    tick();
    req_i = '0; #1;
    check("single_valid", 64'(glb_valid_o), 64'd1);
    check("single_addr", 64'(glb_addr_o), 64'h100);
    check("single_wdata", 64'(glb_wdata_o), 64'hDEAD_BEEF);
    check("single_web", 64'(glb_web_o), 64'hF);
    check("single_cnt_pre", 64'(wr_cnt_o), 64'd0);
    tick();
    check("single_cnt", 64'(wr_cnt_o), 64'd1);
    check("single_drained", 64'(glb_valid_o), 64'd0);

    // reset pointer and counters, then fairness with everyone requesting
    rst = 1'b1; tick(); rst = 1'b0;
    req_i = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("fair_permit_%0d", i), 64'(permit_pop_o), 64'(8'h01 << (i % 8)));
      if (i > 0) check($sformatf("fair_addr_%0d", i), 64'(glb_addr_o), 64'(ch_addr[(i - 1) % 8]));
      tick();
    end
    req_i = '0;
    tick();
    check("fair_cnt", 64'(wr_cnt_o), 64'd16);
    check("fair_idle", 64'(glb_valid_o), 64'd0);
    check("sat_cnt_16", 64'(s_cnt), 64'd15);

    // backpressure: stage holds channel 0 at 0x200
    ch_addr[0] = 32'h200;
    req_i = 8'h01; glb_ready_i = 1'b0;
    tick();
    req_i = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_permit_%0d", i), 64'(permit_pop_o), 64'd0);
      check($sformatf("bp_addr_%0d", i), 64'(glb_addr_o), 64'h200);
      check($sformatf("bp_valid_%0d", i), 64'(glb_valid_o), 64'd1);
      check($sformatf("bp_wdata_%0d", i), 64'(glb_wdata_o), 64'(ch_data[0]));
      tick();
    end
    glb_ready_i = 1'b1; #1;
    check("bp_release_permit", 64'(permit_pop_o), 64'h02);
    tick();
    check("bp_release_valid", 64'(glb_valid_o), 64'd1);
    check("bp_release_addr", 64'(glb_addr_o), 64'(ch_addr[1]));
    check("bp_cnt", 64'(wr_cnt_o), 64'd17);
    check("sat_cnt_hold", 64'(s_cnt), 64'd15);
    req_i = '0;
    tick();
    check("bp_drain_cnt", 64'(wr_cnt_o), 64'd18);

    // wrap-around from pointer 7
    req_i = 8'h40;
    tick();
    req_i = 8'b1000_0001; #1;
    check("wrap_first", 64'(permit_pop_o), 64'h80);
    tick(); #1;
    check("wrap_second", 64'(permit_pop_o), 64'h01);
    check("wrap_addr7", 64'(glb_addr_o), 64'(ch_addr[7]));
    tick();
    req_i = '0; #1;
    check("wrap_addr0", 64'(glb_addr_o), 64'h200);
    tick();
    check("wrap_cnt", 64'(wr_cnt_o), 64'd21);

    // clear coincident with a handshake, then clear alone
    req_i = 8'h01;
    tick();
    req_i = '0; cnt_clr_i = 1'b1;
    tick();
    check("clr_with_hs", 64'(wr_cnt_o), 64'd1);
    tick();
    cnt_clr_i = 1'b0;
    check("clr_alone", 64'(wr_cnt_o), 64'd0);

    // reset while holding a write under backpressure
    req_i = 8'hFF; glb_ready_i = 1'b0;
    tick();
    check("mid_valid_pre", 64'(glb_valid_o), 64'd1);
    rst = 1'b1; #1;
    check("mid_permit_in_rst", 64'(permit_pop_o), 64'd0);
    tick();
    check("mid_valid", 64'(glb_valid_o), 64'd0);
    check("mid_addr", 64'(glb_addr_o), 64'd0);
    rst = 1'b0; glb_ready_i = 1'b1; #1;
    check("mid_first_grant", 64'(permit_pop_o), 64'h01);
    tick();
    check("mid_stage_addr", 64'(glb_addr_o), 64'h200);
    check("mid_cnt", 64'(wr_cnt_o), 64'd0);
    req_i = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opsum_glb_write_arbiter.md
Name: opsum_glb_write_arbiter

Overview:
Sits directly downstream of the NUM_CH opsum FIFO controllers in the token engine. Each controller raises a GLB write request carrying its FIFO head word, address and byte enables. This block picks one requester per cycle by round-robin and returns a one-hot permit, which the controller uses as its FIFO pop strobe. It registers the winning write into a single-entry output stage that drives the GLB write port with a valid/ready handshake.

Parameters:
NUM_CH, 8, number of opsum FIFO controllers (requesters), ≥2
DATA_W, 32, GLB write data width
ADDR_W, 32, GLB address width
WEB_W, 4, byte-enable width (DATA_W/8)
CNT_W, 16, width of the accepted-write counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  NUM_CH  per-channel write request (opsum_glb_write_req)
addr_i  in  NUM_CH*ADDR_W  per-channel write address, channel k at [k*ADDR_W +: ADDR_W]
web_i  in  NUM_CH*WEB_W  per-channel byte enables, passed through unmodified
data_i  in  NUM_CH*DATA_W  per-channel FIFO head data (FWFT, valid whenever req_i[k]=1)
permit_pop_o  out  NUM_CH  one-hot grant; controller pops its FIFO in the same cycle
glb_valid_o  out  1  output stage holds a write
glb_addr_o  out  ADDR_W  GLB write address
glb_web_o  out  WEB_W  GLB byte enables
glb_wdata_o  out  DATA_W  GLB write data
glb_ready_i  in  1  GLB accepts the write this cycle (handshake = valid & ready)
cnt_clr_i  in  1  synchronous clear of wr_cnt_o
wr_cnt_o  out  CNT_W  number of GLB handshakes completed
busy_o  out  1  glb_valid_o | (|req_i)

Behaviour:
- Reset (rst=1 at posedge): glb_valid_o=0; glb_addr_o, glb_web_o and glb_wdata_o = 0; rr_ptr=0; wr_cnt_o=0. permit_pop_o is forced to 0 while rst=1. Reset mid-transfer drops the held write with no handshake.
- slot_free = !glb_valid_o | glb_ready_i. This is a combinational, same-cycle drain.
- Grant is combinational. If slot_free and |req_i, grant the first set req_i bit scanning rr_ptr, rr_ptr+1, … wrapping modulo NUM_CH. Otherwise permit_pop_o=0.
- permit_pop_o is at most one-hot and never asserted for a channel with req_i=0. There is no combinational path from permit_pop_o back to req_i.
- On a grant to channel k at posedge:
  - Output stage loads addr_i[k], web_i[k] and data_i[k], and sets glb_valid_o=1.
  - rr_ptr becomes (k+1) mod NUM_CH; this is wrap-around, so k=NUM_CH-1 gives 0.
- Handshake without a new grant: glb_valid_o becomes 0 and the data registers hold their values.
- No handshake (glb_valid_o=1, glb_ready_i=0): all output registers hold, and permit_pop_o=0. This is backpressure into the FIFOs.
- Handshake and new grant in the same cycle: the output stage is reloaded and glb_valid_o stays 1. Full throughput is one write per cycle.
- Latency: req_i to glb_valid_o is 1 cycle when the slot is free.
- No request (req_i=0): rr_ptr holds.
- wr_cnt_o:
  - Increments by 1 on each handshake and saturates at 2^CNT_W-1.
  - cnt_clr_i clears it. If cnt_clr_i and a handshake occur in the same cycle, the result is 1, since clear-then-count captures the in-flight write.
- Outputs must not change while glb_valid_o=1 and glb_ready_i=0. This is the stability rule for the GLB side.

Decomposition:
- Shared package opsum_arb_pkg:
  - parameter defaults NUM_CH, DATA_W, ADDR_W, WEB_W;
  - the glb_wr_t struct {addr, web, data} used for the output stage and by the GLB-side consumer.
- One natural sub-module: rr_arbiter. It takes req, ptr and enable, and returns a one-hot grant and the grant index. It is purely combinational and reusable for the ifmap/weight read arbiters.
- Pointer update and the output stage stay in the top module.

Test Plan:
- Single requester: req_i=8'b0000_0100, addr_i[2]=0x100, data_i[2]=0xDEADBEEF, web_i[2]=4'hF, glb_ready_i=1 → permit_pop_o=8'h04 in the same cycle. Next cycle glb_valid_o=1, glb_addr_o=0x100, glb_wdata_o=0xDEADBEEF. wr_cnt_o=1 after the handshake.
- Fairness: all 8 requesters held high and ready=1 for 16 cycles → grants follow the order 0,1,…,7,0,…,7 with no channel granted twice before every other channel is granted once. wr_cnt_o=16.
- Backpressure: the output stage is holding addr=0x200 with glb_ready_i=0 for 5 cycles and req_i=8'hFF → permit_pop_o=0 and outputs are stable all 5 cycles. When ready rises, a grant issues the same cycle and glb_valid_o stays 1.
- Wrap-around: rr_ptr=7 and req_i=8'b1000_0001 → channel 7 is granted first, then channel 0.
- Counter edge cases:
  - cnt_clr_i coincident with a handshake → wr_cnt_o=1.
  - Preload near 2^16-1 with CNT_W=16 → wr_cnt_o saturates at 0xFFFF.
- Mid-operation reset: rst asserted while glb_valid_o=1 and req_i=8'hFF → next cycle glb_valid_o=0, permit_pop_o=0, rr_ptr=0. After rst falls, the first grant goes to channel 0.
